// File: rtl/pi1_arbiter_pkg.sv
// Shared definitions for the pi1 round-robin arbiter: op encodings, FSM state, clog2.
// Build option PI1ARB_FIXEDPRIO_EN (see pi1_arbiter.sv) needs nothing from this package.
package pi1_arbiter_pkg;

  localparam logic [1:0] MEMNOOP        = 2'b00;
  localparam logic [1:0] MEMWRITEOP     = 2'b01;
  localparam logic [1:0] MEMREADOP      = 2'b10;
  localparam logic [1:0] MEMREADWRITEOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pi1_arbiter_rrsel.sv
// Combinational circular priority picker: first requester at or after ptr_i wins.
// With PI1ARB_FIXEDPRIO_EN the parent ties ptr_i to zero, giving lowest-index priority.
module pi1_arbiter_rrsel
  import pi1_arbiter_pkg::*;
#(
  parameter  int unsigned MSTRCNT = 2,
  localparam int unsigned IDXW    = clog2(MSTRCNT)
) (
  input  logic [MSTRCNT-1:0] req_i,
  input  logic [IDXW-1:0]    ptr_i,
  output logic [MSTRCNT-1:0] gnt_o,
  output logic [IDXW-1:0]    idx_o,
  output logic               vld_o
);

  logic [IDXW:0] cand;

  // One extra bit on cand so ptr+offset can exceed MSTRCNT-1 before the wrap.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < MSTRCNT; off++) begin
      cand = {1'b0, ptr_i} + (IDXW+1)'(off);
      if (cand >= (IDXW+1)'(MSTRCNT)) cand = cand - (IDXW+1)'(MSTRCNT);
      if (!vld_o && req_i[cand[IDXW-1:0]]) begin
        vld_o                  = 1'b1;
        gnt_o[cand[IDXW-1:0]]  = 1'b1;
        idx_o                  = cand[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/pi1_arbiter.sv
// Merges MSTRCNT pi1 master ports into one slave port, one transaction in flight.
// Define PI1ARB_FIXEDPRIO_EN for lowest-index-wins priority instead of round-robin.
module pi1_arbiter
  import pi1_arbiter_pkg::*;
#(
  parameter  int unsigned ARCHBITSZ = 32,
  parameter  int unsigned MSTRCNT   = 2,
  localparam int unsigned SELBITSZ  = ARCHBITSZ / 8,
  localparam int unsigned ADDRBITSZ = ARCHBITSZ - clog2(SELBITSZ),
  localparam int unsigned IDXW      = clog2(MSTRCNT)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [2*MSTRCNT-1:0]          m_op_i,
  input  logic [ADDRBITSZ*MSTRCNT-1:0]  m_addr_i,
  input  logic [ARCHBITSZ*MSTRCNT-1:0]  m_data_i,
  input  logic [SELBITSZ*MSTRCNT-1:0]   m_sel_i,
  output logic [ARCHBITSZ-1:0]          m_data_o,
  output logic [MSTRCNT-1:0]            m_rdy_o,
  output logic [1:0]                    s_op_o,
  output logic [ADDRBITSZ-1:0]          s_addr_o,
  output logic [ARCHBITSZ-1:0]          s_data_o,
  output logic [SELBITSZ-1:0]           s_sel_o,
  input  logic [ARCHBITSZ-1:0]          s_data_i,
  input  logic                          s_rdy_i
);

  state_t                state_q, state_d;
  logic [IDXW-1:0]       grant_q, grant_d;
  logic [1:0]            s_op_q, s_op_d;
  logic [ADDRBITSZ-1:0]  s_addr_q, s_addr_d;
  logic [ARCHBITSZ-1:0]  s_data_q, s_data_d;
  logic [SELBITSZ-1:0]   s_sel_q, s_sel_d;
  logic [ARCHBITSZ-1:0]  m_data_q, m_data_d;
  logic [MSTRCNT-1:0]    m_rdy_q, m_rdy_d;

  logic [MSTRCNT-1:0]    req;
  logic [IDXW-1:0]       sel_ptr;
  logic [MSTRCNT-1:0]    win_gnt;
  logic [IDXW-1:0]       win_idx;
  logic                  win_vld;
  logic [1:0]            win_op;
  logic [ADDRBITSZ-1:0]  win_addr;
  logic [ARCHBITSZ-1:0]  win_data;
  logic [SELBITSZ-1:0]   win_sel;
  logic [IDXW-1:0]       grant_nxt;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < MSTRCNT; i++) begin
      req[i] = (m_op_i[2*i +: 2] != MEMNOOP);
    end
  end

`ifdef PI1ARB_FIXEDPRIO_EN
  assign sel_ptr = '0;
`else
  logic [IDXW-1:0] ptr_q, ptr_d;

  assign sel_ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP) ptr_d = grant_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`endif

  assign grant_nxt = (grant_q == IDXW'(MSTRCNT-1)) ? '0 : grant_q + IDXW'(1);

  pi1_arbiter_rrsel #(
    .MSTRCNT (MSTRCNT)
  ) u_rrsel (
    .req_i (req),
    .ptr_i (sel_ptr),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  // One-hot AND-OR mux of the winning master's request fields.
  always_comb begin
    win_op   = '0;
    win_addr = '0;
    win_data = '0;
    win_sel  = '0;
    for (int unsigned i = 0; i < MSTRCNT; i++) begin
      if (win_gnt[i]) begin
        win_op   = win_op   | m_op_i[2*i +: 2];
        win_addr = win_addr | m_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
        win_data = win_data | m_data_i[ARCHBITSZ*i +: ARCHBITSZ];
        win_sel  = win_sel  | m_sel_i[SELBITSZ*i +: SELBITSZ];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    s_op_d   = s_op_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    s_sel_d  = s_sel_q;
    m_data_d = m_data_q;
    m_rdy_d  = '0;
    case (state_q)
      IDLE: begin
        s_op_d = MEMNOOP;
        if (win_vld) begin
          s_op_d   = win_op;
          s_addr_d = win_addr;
          s_data_d = win_data;
          s_sel_d  = win_sel;
          grant_d  = win_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (s_rdy_i) begin
          m_data_d          = s_data_i;
          s_op_d            = MEMNOOP;
          m_rdy_d[grant_q]  = 1'b1;
          state_d           = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      s_op_q   <= MEMNOOP;
      s_addr_q <= '0;
      s_data_q <= '0;
      s_sel_q  <= '0;
      m_data_q <= '0;
      m_rdy_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      s_op_q   <= s_op_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      s_sel_q  <= s_sel_d;
      m_data_q <= m_data_d;
      m_rdy_q  <= m_rdy_d;
    end
  end

  assign s_op_o   = s_op_q;
  assign s_addr_o = s_addr_q;
  assign s_data_o = s_data_q;
  assign s_sel_o  = s_sel_q;
  assign m_data_o = m_data_q;
  assign m_rdy_o  = m_rdy_q;

endmodule

// File: tb/tb_pi1_arbiter.sv
// Directed bench for pi1_arbiter (2 masters, 32-bit); expectations follow PI1ARB_FIXEDPRIO_EN.
module tb_pi1_arbiter;

`ifdef PI1ARB_FIXEDPRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  m_op_i;
  logic [59:0] m_addr_i;
  logic [63:0] m_data_i;
  logic [7:0]  m_sel_i;
  logic [31:0] m_data_o;
  logic [1:0]  m_rdy_o;
  logic [1:0]  s_op_o;
  logic [29:0] s_addr_o;
  logic [31:0] s_data_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_data_i;
  logic        s_rdy_i;

  int vectors = 0;
  int errs    = 0;

  pi1_arbiter #(
    .ARCHBITSZ (32),
    .MSTRCNT   (2)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .m_op_i   (m_op_i),
    .m_addr_i (m_addr_i),
    .m_data_i (m_data_i),
    .m_sel_i  (m_sel_i),
    .m_data_o (m_data_o),
    .m_rdy_o  (m_rdy_o),
    .s_op_o   (s_op_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_sel_o  (s_sel_o),
    .s_data_i (s_data_i),
    .s_rdy_i  (s_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic [1:0] op, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    m_op_i[2*i +: 2]    = op;
    m_addr_i[30*i +: 30] = a;
    m_data_i[32*i +: 32] = d;
    m_sel_i[4*i +: 4]    = s;
  endtask

  initial begin
    int g;
    rst_ni   = 1'b0;
    m_op_i   = '0;
    m_addr_i = '0;
    m_data_i = '0;
    m_sel_i  = '0;
    s_data_i = '0;
    s_rdy_i  = 1'b0;
    tick();
    tick();
    chk("rst_s_op", 64'(s_op_o), 64'h0);
    chk("rst_s_addr", 64'(s_addr_o), 64'h0);
    chk("rst_s_data", 64'(s_data_o), 64'h0);
    chk("rst_s_sel", 64'(s_sel_o), 64'h0);
    chk("rst_m_data", 64'(m_data_o), 64'h0);
    chk("rst_m_rdy", 64'(m_rdy_o), 64'h0);
    rst_ni = 1'b1;
    tick();

    // single read from m0, three slave wait cycles
    set_m(0, 2'b10, 30'h100, 32'h0, 4'hF);
    tick();
    chk("rd_issue_op", 64'(s_op_o), 64'h2);
    chk("rd_issue_addr", 64'(s_addr_o), 64'h100);
    for (int c = 0; c < 3; c++) begin
      chk("rd_wait_op", 64'(s_op_o), 64'h2);
      chk("rd_wait_rdy", 64'(m_rdy_o), 64'h0);
      tick();
    end
    s_rdy_i  = 1'b1;
    s_data_i = 32'hDEADBEEF;
    tick();
    chk("rd_resp_rdy", 64'(m_rdy_o), 64'h1);
    chk("rd_resp_data", 64'(m_data_o), 64'hDEADBEEF);
    chk("rd_resp_op", 64'(s_op_o), 64'h0);
    s_rdy_i = 1'b0;
    set_m(0, 2'b00, 30'h0, 32'h0, 4'h0);
    tick();
    chk("rd_after_rdy", 64'(m_rdy_o), 64'h0);
    chk("rd_after_op", 64'(s_op_o), 64'h0);

    // stray slave strobe in IDLE
    s_rdy_i  = 1'b1;
    s_data_i = 32'hBAD0BAD0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stray_rdy", 64'(m_rdy_o), 64'h0);
      chk("stray_data", 64'(m_data_o), 64'hDEADBEEF);
      chk("stray_op", 64'(s_op_o), 64'h0);
    end
    s_rdy_i = 1'b0;

    // write passthrough from m1
    set_m(1, 2'b01, 30'h55, 32'h12345678, 4'b0011);
    tick();
    chk("wr_op", 64'(s_op_o), 64'h1);
    chk("wr_addr", 64'(s_addr_o), 64'h55);
    chk("wr_data", 64'(s_data_o), 64'h12345678);
    chk("wr_sel", 64'(s_sel_o), 64'h3);
    tick();
    chk("wr_hold_op", 64'(s_op_o), 64'h1);
    chk("wr_hold_rdy", 64'(m_rdy_o), 64'h0);
    s_rdy_i  = 1'b1;
    s_data_i = 32'hAAAA0000;
    tick();
    chk("wr_rdy", 64'(m_rdy_o), 64'h2);
    s_rdy_i = 1'b0;
    set_m(1, 2'b00, 30'h0, 32'h0, 4'h0);
    tick();
    chk("wr_after_rdy", 64'(m_rdy_o), 64'h0);

    // swap from m0, zero wait
    set_m(0, 2'b11, 30'h80, 32'h77, 4'hF);
    tick();
    chk("swap_op", 64'(s_op_o), 64'h3);
    chk("swap_wdata", 64'(s_data_o), 64'h77);
    s_rdy_i  = 1'b1;
    s_data_i = 32'h5;
    tick();
    chk("swap_rdy", 64'(m_rdy_o), 64'h1);
    chk("swap_data", 64'(m_data_o), 64'h5);
    s_rdy_i = 1'b0;
    set_m(0, 2'b00, 30'h0, 32'h0, 4'h0);
    tick();
    chk("swap_after_op", 64'(s_op_o), 64'h0);

    // contention: pointer is 1 after the swap, so round-robin starts at m1
    set_m(0, 2'b10, 30'h200, 32'h0, 4'hF);
    set_m(1, 2'b10, 30'h300, 32'h0, 4'hF);
    s_rdy_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = FIXED ? 0 : ((k % 2 == 0) ? 1 : 0);
      s_data_i = 32'h1000 + 32'(k);
      tick();
      chk("cont_issue_op", 64'(s_op_o), 64'h2);
      chk("cont_issue_addr", 64'(s_addr_o), (g == 0) ? 64'h200 : 64'h300);
      tick();
      chk("cont_rdy", 64'(m_rdy_o), 64'h1 << g);
      chk("cont_data", 64'(m_data_o), 64'h1000 + 64'(k));
      if (k == 3) begin
        set_m(0, 2'b00, 30'h0, 32'h0, 4'h0);
        set_m(1, 2'b00, 30'h0, 32'h0, 4'h0);
        s_rdy_i = 1'b0;
      end
      tick();
      chk("cont_idle_rdy", 64'(m_rdy_o), 64'h0);
      chk("cont_idle_op", 64'(s_op_o), 64'h0);
    end

    // reset while m0 is in ISSUE, m1 pending
    set_m(0, 2'b10, 30'h400, 32'h0, 4'hF);
    tick();
    chk("rsta_issue_addr", 64'(s_addr_o), 64'h400);
    set_m(1, 2'b10, 30'h500, 32'h0, 4'hF);
    tick();
    chk("rsta_hold_op", 64'(s_op_o), 64'h2);
    chk("rsta_hold_addr", 64'(s_addr_o), 64'h400);
    rst_ni = 1'b0;
    set_m(0, 2'b00, 30'h0, 32'h0, 4'h0);
    tick();
    chk("rsta_op", 64'(s_op_o), 64'h0);
    chk("rsta_rdy", 64'(m_rdy_o), 64'h0);
    chk("rsta_addr", 64'(s_addr_o), 64'h0);
    chk("rsta_mdata", 64'(m_data_o), 64'h0);
    rst_ni = 1'b1;
    tick();
    chk("rsta_m1_op", 64'(s_op_o), 64'h2);
    chk("rsta_m1_addr", 64'(s_addr_o), 64'h500);
    s_rdy_i  = 1'b1;
    s_data_i = 32'h11;
    tick();
    chk("rsta_m1_rdy", 64'(m_rdy_o), 64'h2);
    chk("rsta_m1_data", 64'(m_data_o), 64'h11);
    s_rdy_i = 1'b0;
    set_m(1, 2'b00, 30'h0, 32'h0, 4'h0);
    tick();

    // m0 alone moves the pointer to 1; reset must return it to 0
    set_m(0, 2'b10, 30'h600, 32'h0, 4'hF);
    tick();
    s_rdy_i  = 1'b1;
    s_data_i = 32'h22;
    tick();
    chk("rstb_pre_rdy", 64'(m_rdy_o), 64'h1);
    s_rdy_i = 1'b0;
    set_m(0, 2'b00, 30'h0, 32'h0, 4'h0);
    tick();
    set_m(0, 2'b10, 30'h600, 32'h0, 4'hF);
    set_m(1, 2'b10, 30'h700, 32'h0, 4'hF);
    tick();
    chk("rstb_issue_addr", 64'(s_addr_o), FIXED ? 64'h600 : 64'h700);
    rst_ni = 1'b0;
    tick();
    chk("rstb_op", 64'(s_op_o), 64'h0);
    rst_ni = 1'b1;
    tick();
    chk("rstb_regrant_op", 64'(s_op_o), 64'h2);
    chk("rstb_regrant_addr", 64'(s_addr_o), 64'h600);
    s_rdy_i  = 1'b1;
    s_data_i = 32'h33;
    tick();
    chk("rstb_rdy", 64'(m_rdy_o), 64'h1);
    chk("rstb_data", 64'(m_data_o), 64'h33);
    s_rdy_i = 1'b0;
    set_m(0, 2'b00, 30'h0, 32'h0, 4'h0);
    set_m(1, 2'b00, 30'h0, 32'h0, 4'h0);
    tick();
    chk("end_rdy", 64'(m_rdy_o), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
